dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port 16x8 data memory between two requesters: the pipeline MEM stage (CPU) and the debug/program-load port (DBG).
- Arbitration is round-robin. A requester can lock the port for a burst, and a starvation limit bounds how long a lock can hold off the other side.
- Sits between the MEM stage, the debug loader and the data memory. Read data returns one cycle after grant to the requester that issued it.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 8, data width.
- LOCK_MAX, 8, maximum consecutive cycles the non-owner may wait while the other side holds a lock; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held with attributes until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_lock  in  1  keep ownership after this access.
- cpu_gnt  out  1  access accepted at this rising edge (combinational).
- cpu_rvalid  out  1  read data valid (registered).
- cpu_rdata  out  DATA_W  read data; equals mem_rdata when cpu_rvalid=1, else 0.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for DBG.
- mem_en  out  1  memory access strobe (combinational).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.
- owner  out  2  00 = unlocked, 01 = CPU locked, 10 = DBG locked.
- grant_cnt_cpu, grant_cnt_dbg  out  16  grant counters (see Optional Feature).

Behaviour:
Reset values:
- All gnt/rvalid low; all rdata 0.
- mem_en, mem_we low; mem_addr, mem_wdata 0.
- owner=00; last_winner=DBG, so CPU wins the first tie.
- wait counter 0.

State machine (owner): UNLOCKED, LOCK_CPU, LOCK_DBG.
- UNLOCKED:
  - One request → grant it.
  - Both requests → grant the side that is not last_winner.
  - Grant with lock=1 → go to LOCK_<winner>.
- LOCK_X:
  - Only X may be granted.
  - X granted with lock=0 → UNLOCKED next cycle.
  - X req low → release the lock this cycle; the other side may be granted in the same cycle under UNLOCKED rules.
- Starvation guard:
  - In LOCK_X, the wait counter increments each cycle the other side requests and is not granted.
  - When it reaches LOCK_MAX: force UNLOCKED, set last_winner=X, clear the counter. The other side wins the next cycle even if X requests with lock=1.
  - The counter clears on any state change or when the other side's request drops.
- last_winner updates on every grant.

Datapath and handshake:
- The granted requester's we/addr/wdata drive the mem_* outputs in the same cycle as its gnt, with mem_en=1. At most one gnt per cycle.
- Read granted at edge N → <x>_rvalid=1 in cycle N+1, with rdata = mem_rdata. Writes produce no rvalid.
- Back-to-back grants every cycle are allowed (throughput 1 access/cycle). rvalid for the cycle-N read and a gnt for cycle N+1 may coexist.
- Reset asserted mid-operation clears all state immediately. A pending rvalid is dropped; a write whose edge completed stays committed.
- Address wrap: none; ADDR_W bits are passed through unchanged.
- A requester dropping req before gnt withdraws the request; no error is flagged.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - grant_cnt_cpu and grant_cnt_dbg count grants per side.
  - They saturate at 16'hFFFF and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are built. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then CPU read addr 3 alone with mem returning 8'hA5 → cpu_gnt in same cycle, mem_en=1, mem_we=0, mem_addr=3; next cycle cpu_rvalid=1, cpu_rdata=8'hA5, dbg_rvalid=0.
- Both request every cycle, no lock, 4 cycles → grants CPU, DBG, CPU, DBG; exactly one gnt per cycle.
- DBG write addr 5 data 8'h3C, lock=1, then 3 more DBG writes with lock=1 while CPU requests → CPU gets no gnt and owner=10 throughout; the final DBG write with lock=0 → owner=00 and CPU granted the following cycle.
- LOCK_MAX=8, DBG locks continuously while CPU requests → CPU granted on the cycle after 8 waiting cycles; owner returns to 00.
- CPU read granted, reset asserted in the next cycle → cpu_rvalid=0 and owner=00 immediately. After release, a tie goes to CPU.
- With DMEM_ARB_STATS_EN, 5 CPU + 3 DBG grants → grant_cnt_cpu=5, grant_cnt_dbg=3. Without the macro → both read 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the requester, memory and status signals around dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // CPU (pipeline MEM stage) requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_lock;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // DBG (debug / program-load) requester
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  // Data memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic [1:0]        owner;
  logic [15:0]       grant_cnt_cpu;
  logic [15:0]       grant_cnt_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner, grant_cnt_cpu, grant_cnt_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner, grant_cnt_cpu, grant_cnt_dbg
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// MEM stage and the debug loader. Either side may lock the port for a burst;
// a wait counter bounds how long a lock can starve the other side.
// Optional per-side grant counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_MAX);
  localparam logic WIN_CPU = 1'b0;
  localparam logic WIN_DBG = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCK_CPU = 2'b01,
    LOCK_DBG = 2'b10
  } owner_e;

  owner_e           owner_q, owner_d;
  logic             last_winner_q, last_winner_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;

  logic             cpu_gnt;
  logic             dbg_gnt;
  logic [CNT_W-1:0] wait_inc;

  // Grant decision: a live lock wins outright; a lock whose owner dropped req
  // falls through to the ordinary round-robin rules in the same cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (owner_q == LOCK_CPU && bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (owner_q == LOCK_DBG && bus.dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (bus.cpu_req && bus.dbg_req) begin
        if (last_winner_q == WIN_DBG) cpu_gnt = 1'b1;
        else                          dbg_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  // Next owner, round-robin history, starvation counter and read-return flags.
  always_comb begin
    owner_d       = UNLOCKED;
    last_winner_d = last_winner_q;
    wait_cnt_d    = '0;
    wait_inc      = wait_cnt_q + CNT_W'(1);

    if (cpu_gnt) begin
      owner_d       = bus.cpu_lock ? LOCK_CPU : UNLOCKED;
      last_winner_d = WIN_CPU;
    end else if (dbg_gnt) begin
      owner_d       = bus.dbg_lock ? LOCK_DBG : UNLOCKED;
      last_winner_d = WIN_DBG;
    end

    // The lock owner is necessarily the granted side here, so the other side
    // is waiting whenever it requests. Hitting the limit breaks the lock and
    // records the owner as last winner so the waiter wins the next tie.
    if (owner_q == LOCK_CPU && cpu_gnt && bus.dbg_req) begin
      if (wait_inc >= CNT_LIMIT) begin
        owner_d       = UNLOCKED;
        last_winner_d = WIN_CPU;
      end else if (owner_d == owner_q) begin
        wait_cnt_d = wait_inc;
      end
    end else if (owner_q == LOCK_DBG && dbg_gnt && bus.cpu_req) begin
      if (wait_inc >= CNT_LIMIT) begin
        owner_d       = UNLOCKED;
        last_winner_d = WIN_DBG;
      end else if (owner_d == owner_q) begin
        wait_cnt_d = wait_inc;
      end
    end

    cpu_rvalid_d = cpu_gnt && !bus.cpu_we;
    dbg_rvalid_d = dbg_gnt && !bus.dbg_we;
  end

  // Owner FSM and registered read-valid flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q       <= UNLOCKED;
      last_winner_q <= WIN_DBG;
      wait_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      wait_cnt_q    <= wait_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = dbg_rvalid_q ? bus.mem_rdata : '0;
  assign bus.owner      = owner_q;

  // Memory strobe follows the grant; unused fields are held at zero when idle.
  assign bus.mem_en    = cpu_gnt | dbg_gnt;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_we    : (dbg_gnt ? bus.dbg_we    : 1'b0);
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr  : (dbg_gnt ? bus.dbg_addr  : '0);
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : (dbg_gnt ? bus.dbg_wdata : '0);

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt_cpu_q, grant_cnt_cpu_d;
  logic [15:0] grant_cnt_dbg_q, grant_cnt_dbg_d;

  // Saturating per-side grant counters.
  always_comb begin
    grant_cnt_cpu_d = grant_cnt_cpu_q;
    grant_cnt_dbg_d = grant_cnt_dbg_q;
    if (cpu_gnt && grant_cnt_cpu_q != 16'hFFFF) grant_cnt_cpu_d = grant_cnt_cpu_q + 16'd1;
    if (dbg_gnt && grant_cnt_dbg_q != 16'hFFFF) grant_cnt_dbg_d = grant_cnt_dbg_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_cpu_q <= '0;
      grant_cnt_dbg_q <= '0;
    end else begin
      grant_cnt_cpu_q <= grant_cnt_cpu_d;
      grant_cnt_dbg_q <= grant_cnt_dbg_d;
    end
  end

  assign bus.grant_cnt_cpu = grant_cnt_cpu_q;
  assign bus.grant_cnt_dbg = grant_cnt_dbg_q;
`else
  assign bus.grant_cnt_cpu = '0;
  assign bus.grant_cnt_dbg = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 16x8 behavioural memory.
// Inputs change at the falling edge; outputs are sampled 1 ns later.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dmem_port_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural single-port memory: registered read, write on strobe.
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
    mem[3] <= 8'hA5;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [3:0] addr,
                           input logic [7:0] wdata, input logic lock);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_lock = lock;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [3:0] addr,
                           input logic [7:0] wdata, input logic lock);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr;
    bus.dbg_wdata = wdata; bus.dbg_lock = lock;
  endtask

  initial begin
    logic exp_cpu;
    reset = 1'b1;
    drive_cpu(0, 0, 0, 0, 0);
    drive_dbg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_cpu_gnt",    bus.cpu_gnt, 0);
    check("rst_dbg_gnt",    bus.dbg_gnt, 0);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    check("rst_cpu_rdata",  bus.cpu_rdata, 0);
    check("rst_mem_en",     bus.mem_en, 0);
    check("rst_mem_addr",   bus.mem_addr, 0);
    check("rst_mem_wdata",  bus.mem_wdata, 0);
    check("rst_owner",      bus.owner, 0);
    check("rst_cnt_cpu",    bus.grant_cnt_cpu, 0);

    @(negedge clk);
    reset = 1'b0;

    // CPU read of address 3 alone
    drive_cpu(1, 0, 3, 0, 0);
    #1;
    check("t1_cpu_gnt",  bus.cpu_gnt, 1);
    check("t1_dbg_gnt",  bus.dbg_gnt, 0);
    check("t1_mem_en",   bus.mem_en, 1);
    check("t1_mem_we",   bus.mem_we, 0);
    check("t1_mem_addr", bus.mem_addr, 3);
    @(negedge clk);
    drive_cpu(0, 0, 0, 0, 0);
    #1;
    check("t1_cpu_rvalid", bus.cpu_rvalid, 1);
    check("t1_cpu_rdata",  bus.cpu_rdata, 8'hA5);
    check("t1_dbg_rvalid", bus.dbg_rvalid, 0);
    check("t1_idle_gnt",   bus.cpu_gnt, 0);

    // DBG read of address 7 alone (also makes DBG the last winner)
    @(negedge clk);
    drive_dbg(1, 0, 7, 0, 0);
    #1;
    check("d1_dbg_gnt",  bus.dbg_gnt, 1);
    check("d1_cpu_gnt",  bus.cpu_gnt, 0);
    check("d1_mem_addr", bus.mem_addr, 7);
    @(negedge clk);
    drive_dbg(0, 0, 0, 0, 0);
    #1;
    check("d1_dbg_rvalid", bus.dbg_rvalid, 1);
    check("d1_dbg_rdata",  bus.dbg_rdata, 8'h17);
    check("d1_cpu_rvalid", bus.cpu_rvalid, 0);

    // Both request every cycle without lock: strict alternation
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cpu(1, 0, 1, 0, 0);
      drive_dbg(1, 0, 2, 0, 0);
      #1;
      exp_cpu = (k % 2 == 0);
      check($sformatf("rr%0d_cpu_gnt", k), bus.cpu_gnt, exp_cpu);
      check($sformatf("rr%0d_dbg_gnt", k), bus.dbg_gnt, !exp_cpu);
      check($sformatf("rr%0d_mem_addr", k), bus.mem_addr, exp_cpu ? 1 : 2);
      if (k > 0) begin
        check($sformatf("rr%0d_cpu_rvalid", k), bus.cpu_rvalid, !exp_cpu);
        check($sformatf("rr%0d_dbg_rvalid", k), bus.dbg_rvalid, exp_cpu);
      end
    end
    @(negedge clk);
    drive_cpu(0, 0, 0, 0, 0);
    drive_dbg(0, 0, 0, 0, 0);
    #1;
    check("rr_dbg_rdata", bus.dbg_rdata, 8'h12);

    // DBG locked write burst while CPU waits
    @(negedge clk);
    drive_dbg(1, 1, 5, 8'h3C, 1);
    #1;
    check("lk_dbg_gnt",   bus.dbg_gnt, 1);
    check("lk_mem_we",    bus.mem_we, 1);
    check("lk_mem_addr",  bus.mem_addr, 5);
    check("lk_mem_wdata", bus.mem_wdata, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_dbg(1, 1, 4'(6 + k), 8'(8'h40 + k), 1);
      drive_cpu(1, 0, 0, 0, 0);
      #1;
      check($sformatf("lk%0d_cpu_gnt", k), bus.cpu_gnt, 0);
      check($sformatf("lk%0d_dbg_gnt", k), bus.dbg_gnt, 1);
      check($sformatf("lk%0d_owner", k),   bus.owner, 2'b10);
    end
    @(negedge clk);
    drive_dbg(1, 1, 9, 8'h55, 0);
    #1;
    check("lkend_cpu_gnt", bus.cpu_gnt, 0);
    check("lkend_owner",   bus.owner, 2'b10);
    @(negedge clk);
    drive_dbg(1, 0, 5, 0, 0);
    #1;
    check("lkrel_owner",   bus.owner, 2'b00);
    check("lkrel_cpu_gnt", bus.cpu_gnt, 1);
    check("lkrel_dbg_gnt", bus.dbg_gnt, 0);
    @(negedge clk);
    drive_cpu(0, 0, 0, 0, 0);
    #1;
    check("lkrel_dbg_gnt2",   bus.dbg_gnt, 1);
    check("lkrel_cpu_rdata",  bus.cpu_rdata, 8'h10);
    @(negedge clk);
    drive_dbg(0, 0, 0, 0, 0);
    #1;
    check("lkrel_dbg_rdata",  bus.dbg_rdata, 8'h3C);

    // Starvation guard: DBG holds lock, CPU waits LOCK_MAX cycles
    @(negedge clk);
    drive_dbg(1, 0, 1, 0, 1);
    #1;
    check("sv_dbg_gnt", bus.dbg_gnt, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive_cpu(1, 0, 2, 0, 0);
      #1;
      check($sformatf("sv%0d_cpu_gnt", k), bus.cpu_gnt, 0);
      check($sformatf("sv%0d_owner", k),   bus.owner, 2'b10);
    end
    @(negedge clk);
    #1;
    check("sv_break_owner",   bus.owner, 2'b00);
    check("sv_break_cpu_gnt", bus.cpu_gnt, 1);
    check("sv_break_dbg_gnt", bus.dbg_gnt, 0);
    @(negedge clk);
    drive_cpu(0, 0, 0, 0, 0);
    drive_dbg(0, 0, 0, 0, 0);
    #1;
    check("sv_after_owner", bus.owner, 2'b00);

    // Reset right after a locked CPU read is granted
    @(negedge clk);
    drive_cpu(1, 0, 3, 0, 1);
    #1;
    check("mr_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge clk);
    drive_cpu(1, 0, 3, 0, 0);
    drive_dbg(1, 0, 4, 0, 0);
    reset = 1'b1;
    #1;
    check("mr_cpu_rvalid", bus.cpu_rvalid, 0);
    check("mr_owner",      bus.owner, 2'b00);
    check("mr_cpu_gnt",    bus.cpu_gnt, 0);
    check("mr_mem_en",     bus.mem_en, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_tie_cpu_gnt", bus.cpu_gnt, 1);
    check("mr_tie_dbg_gnt", bus.dbg_gnt, 0);

    // Grant counting: ties alternate, then CPU alone twice (5 CPU, 3 DBG)
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("st%0d_cpu_gnt", k), bus.cpu_gnt, (k % 2 == 0));
    end
    @(negedge clk);
    drive_dbg(0, 0, 0, 0, 0);
    #1;
    check("st6_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge clk);
    #1;
    check("st7_cpu_gnt", bus.cpu_gnt, 1);
    @(negedge clk);
    drive_cpu(0, 0, 0, 0, 0);
    #1;
`ifdef DMEM_ARB_STATS_EN
    check("st_cnt_cpu", bus.grant_cnt_cpu, 5);
    check("st_cnt_dbg", bus.grant_cnt_dbg, 3);
`else
    check("st_cnt_cpu", bus.grant_cnt_cpu, 0);
    check("st_cnt_dbg", bus.grant_cnt_dbg, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
